// File: rtl/nvm_neuron_pkg.sv
// Shared types and constants for the neuron array: FSM states, reset modes
// and default geometry.
package nvm_neuron_pkg;

    localparam int N_NEURONS_DEF = 64;
    localparam int LANES_DEF     = 16;
    localparam int POT_W_DEF     = 16;
    localparam int STIM_W_DEF    = 16;

    localparam logic RST_ZERO = 1'b0;
    localparam logic RST_SUB  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        DONE = 2'd2
    } nvm_state_e;

endpackage

// File: rtl/nvm_sat_addsub.sv
// Signed saturating add/subtract; one per lane, shared by the accumulate
// (add stimulus) and fire (subtract threshold) paths.
module nvm_sat_addsub #(
    parameter int POT_W = 16
) (
    input  logic signed [POT_W-1:0] a_i,
    input  logic signed [POT_W-1:0] b_i,
    input  logic                    sub_i,
    output logic signed [POT_W-1:0] y_o
);

    localparam logic signed [POT_W-1:0] SAT_MAX = {1'b0, {(POT_W-1){1'b1}}};
    localparam logic signed [POT_W-1:0] SAT_MIN = {1'b1, {(POT_W-1){1'b0}}};

    logic signed [POT_W:0] a_x;
    logic signed [POT_W:0] b_x;
    logic signed [POT_W:0] wide;

    assign a_x = {a_i[POT_W-1], a_i};
    assign b_x = {b_i[POT_W-1], b_i};

    always_comb begin
        wide = sub_i ? (a_x - b_x) : (a_x + b_x);
        // Top two bits disagree only when the result left the POT_W range.
        if (wide[POT_W] != wide[POT_W-1]) begin
            y_o = wide[POT_W] ? SAT_MIN : SAT_MAX;
        end else begin
            y_o = wide[POT_W-1:0];
        end
    end

endmodule

// File: rtl/nvm_neuron_array.sv
// Array of leaky integrate-and-fire neurons: lane-parallel accumulate in IDLE,
// then a group-by-group spike readout with reset/leak applied per transfer.
module nvm_neuron_array
    import nvm_neuron_pkg::*;
#(
    parameter int N_NEURONS = N_NEURONS_DEF,
    parameter int LANES     = LANES_DEF,
    parameter int POT_W     = POT_W_DEF,
    parameter int STIM_W    = STIM_W_DEF,
    localparam int G        = N_NEURONS / LANES,
    localparam int GW       = (G > 1) ? $clog2(G) : 1
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_ni,
    input  logic signed [POT_W-1:0]  cfg_threshold,
    input  logic        [POT_W-2:0]  cfg_leak,
    input  logic                     cfg_reset_mode,
    input  logic                     acc_valid,
    output logic                     acc_ready,
    input  logic        [GW-1:0]     acc_group,
    input  logic signed [STIM_W-1:0] acc_stimuli,
    input  logic        [LANES-1:0]  acc_conn,
    input  logic                     fire_req,
    output logic                     busy,
    output logic                     spk_valid,
    input  logic                     spk_ready,
    output logic        [GW-1:0]     spk_group,
    output logic        [LANES-1:0]  spk_data,
    output logic                     fire_done
);

    localparam int IW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

    nvm_state_e state_q, state_d;
    logic [GW-1:0] cnt_q, cnt_d;
    logic signed [POT_W-1:0] pot_q [N_NEURONS];
    logic signed [POT_W-1:0] pot_d [N_NEURONS];

    logic                    fire_path;
    logic                    acc_xfer;
    logic                    spk_xfer;
    logic                    grp_ok;
    logic [GW-1:0]           g_sel;
    logic [IW-1:0]           base;
    logic signed [POT_W-1:0] stim_ext;

    logic signed [POT_W-1:0] lane_pot  [LANES];
    logic signed [POT_W-1:0] lane_b    [LANES];
    logic signed [POT_W-1:0] lane_res  [LANES];
    logic signed [POT_W-1:0] lane_leak [LANES];
    logic [LANES-1:0]        lane_spk;

    logic signed [POT_W:0]   pw_x;
    logic signed [POT_W:0]   lk_x;
    logic signed [POT_W:0]   lk_t;

    // FSM: state register and next-state/output logic
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_ready = 1'b0;
        busy      = 1'b1;
        spk_valid = 1'b0;
        fire_done = 1'b0;
        case (state_q)
            IDLE: begin
                acc_ready = 1'b1;
                busy      = 1'b0;
                if (fire_req) begin
                    state_d = FIRE;
                    cnt_d   = '0;
                end
            end
            FIRE: begin
                spk_valid = 1'b1;
                if (spk_ready) begin
                    if (int'(cnt_q) == G - 1) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                fire_done = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign fire_path = (state_q == FIRE);
    assign acc_xfer  = acc_valid & acc_ready;
    assign spk_xfer  = spk_valid & spk_ready;
    assign g_sel     = fire_path ? cnt_q : acc_group;
    assign grp_ok    = int'(g_sel) < G;
    assign base      = IW'(int'(g_sel) * LANES);
    assign stim_ext  = POT_W'(acc_stimuli);
    assign spk_group = cnt_q;
    assign spk_data  = fire_path ? lane_spk : '0;

    // Per-lane operand fetch, spike compare and leak toward zero
    always_comb begin
        pw_x = '0;
        lk_x = $signed({2'b00, cfg_leak});
        lk_t = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_pot[i] = '0;
            if (grp_ok) begin
                lane_pot[i] = pot_q[base + IW'(i)];
            end
            lane_spk[i] = (lane_pot[i] >= cfg_threshold);
            lane_b[i]   = fire_path ? cfg_threshold : stim_ext;
            pw_x        = (POT_W+1)'(lane_pot[i]);
            if (pw_x > 0) begin
                lk_t         = pw_x - lk_x;
                lane_leak[i] = (lk_t < 0) ? '0 : lk_t[POT_W-1:0];
            end else begin
                lk_t         = pw_x + lk_x;
                lane_leak[i] = (lk_t > 0) ? '0 : lk_t[POT_W-1:0];
            end
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        nvm_sat_addsub #(.POT_W(POT_W)) u_sat (
            .a_i   (lane_pot[gi]),
            .b_i   (lane_b[gi]),
            .sub_i (fire_path),
            .y_o   (lane_res[gi])
        );
    end

    always_comb begin
        pot_d = pot_q;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (grp_ok) begin
                if (acc_xfer && acc_conn[i]) begin
                    pot_d[base + IW'(i)] = lane_res[i];
                end else if (spk_xfer) begin
                    if (lane_spk[i]) begin
                        pot_d[base + IW'(i)] = (cfg_reset_mode == RST_SUB) ? lane_res[i] : '0;
                    end else begin
                        pot_d[base + IW'(i)] = lane_leak[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            for (int unsigned n = 0; n < N_NEURONS; n++) begin
                pot_q[n] <= '0;
            end
        end else begin
            for (int unsigned n = 0; n < N_NEURONS; n++) begin
                pot_q[n] <= pot_d[n];
            end
        end
    end

endmodule

// File: tb/tb_nvm_neuron_array.sv
// Randomized self-checking bench for nvm_neuron_array against an array-based
// behavioural model of integrate, fire, reset and leak.
module tb_nvm_neuron_array;

    localparam int N  = 64;
    localparam int L  = 16;
    localparam int G  = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] cfg_threshold = '0;
    logic        [14:0] cfg_leak = '0;
    logic               cfg_reset_mode = 1'b0;
    logic               acc_valid = 1'b0;
    logic               acc_ready;
    logic        [1:0]  acc_group = '0;
    logic signed [15:0] acc_stimuli = '0;
    logic        [15:0] acc_conn = '0;
    logic               fire_req = 1'b0;
    logic               busy;
    logic               spk_valid;
    logic               spk_ready = 1'b0;
    logic        [1:0]  spk_group;
    logic        [15:0] spk_data;
    logic               fire_done;

    int errors = 0;
    int checks = 0;
    int model [N];
    int thr_m = 0;
    int leak_m = 0;
    int mode_m = 0;

    always #5 clk = ~clk;

    nvm_neuron_array dut (
        .wb_clk_i       (clk),
        .wb_rst_ni      (rst_n),
        .cfg_threshold  (cfg_threshold),
        .cfg_leak       (cfg_leak),
        .cfg_reset_mode (cfg_reset_mode),
        .acc_valid      (acc_valid),
        .acc_ready      (acc_ready),
        .acc_group      (acc_group),
        .acc_stimuli    (acc_stimuli),
        .acc_conn       (acc_conn),
        .fire_req       (fire_req),
        .busy           (busy),
        .spk_valid      (spk_valid),
        .spk_ready      (spk_ready),
        .spk_group      (spk_group),
        .spk_data       (spk_data),
        .fire_done      (fire_done)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic logic [L-1:0] model_spk(input int g);
        logic [L-1:0] s;
        for (int i = 0; i < L; i++) s[i] = (model[g*L+i] >= thr_m);
        return s;
    endfunction

    task automatic model_acc(input int g, input int s, input int c);
        if (g < G) begin
            for (int i = 0; i < L; i++)
                if (c[i]) model[g*L+i] = sat16(longint'(model[g*L+i]) + s);
        end
    endtask

    task automatic model_fire_grp(input int g);
        int p;
        for (int i = 0; i < L; i++) begin
            p = model[g*L+i];
            if (p >= thr_m) begin
                p = (mode_m != 0) ? sat16(longint'(p) - thr_m) : 0;
            end else if (p > 0) begin
                p = (p > leak_m) ? p - leak_m : 0;
            end else if (p < 0) begin
                p = (-p > leak_m) ? p + leak_m : 0;
            end
            model[g*L+i] = p;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) model[i] = 0;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < N; i++)
            check($sformatf("%s_pot[%0d]", tag, i), dut.pot_q[i], model[i]);
    endtask

    task automatic set_cfg(input int t, input int lk, input int m);
        @(negedge clk);
        thr_m = t; leak_m = lk; mode_m = m;
        cfg_threshold  = 16'(t);
        cfg_leak       = 15'(lk);
        cfg_reset_mode = (m != 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_acc(input int g, input int s, input int c);
        @(negedge clk);
        check("acc_ready_idle", acc_ready, 1);
        acc_valid = 1'b1; acc_group = 2'(g); acc_stimuli = 16'(s); acc_conn = 16'(c);
        @(posedge clk);
        #1 acc_valid = 1'b0;
        model_acc(g, s, c);
    endtask

    task automatic do_fire(input bit with_acc, input int ag, input int as, input int ac,
                           input int stall_g, input int stall_n);
        int words, dones, g, st;
        bit fin;
        @(negedge clk);
        fire_req = 1'b1;
        if (with_acc) begin
            acc_valid = 1'b1; acc_group = 2'(ag); acc_stimuli = 16'(as); acc_conn = 16'(ac);
        end
        @(posedge clk);
        #1 fire_req = 1'b0; acc_valid = 1'b0;
        if (with_acc) model_acc(ag, as, ac);
        words = 0; dones = 0; g = 0; st = 0; fin = 1'b0;
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            @(negedge clk);
            if (fire_done) dones++;
            if (spk_valid) begin
                check("spk_group", spk_group, g);
                check("spk_data", spk_data, model_spk(g));
                if (g == stall_g && st < stall_n) begin
                    spk_ready = 1'b0; st++;
                    fire_req = 1'b1; acc_valid = 1'b1;
                    acc_group = '0; acc_conn = '1; acc_stimuli = 16'sd1000;
                    check("acc_ready_fire", acc_ready, 0);
                end else begin
                    fire_req = 1'b0; acc_valid = 1'b0;
                    spk_ready = ($urandom_range(0, 3) != 0);
                    if (spk_ready) begin
                        model_fire_grp(g);
                        words++; g++;
                    end
                end
            end else begin
                spk_ready = 1'b0; fire_req = 1'b0; acc_valid = 1'b0;
                if (!busy) fin = 1'b1;
            end
        end
        check("fire_finished", fin, 1);
        check("spk_words", words, G);
        check("fire_done_pulses", dones, 1);
        check("busy_after_fire", busy, 0);
    endtask

    initial begin
        logic [15:0] r16;
        model_clear();
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_spk_valid", spk_valid, 0);
        check("rst_fire_done", fire_done, 0);
        check_all("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("ready_after_release", acc_ready, 1);

        // Basic integrate-and-fire, with a stalled group 2 and ignored requests
        set_cfg(250, 0, 0);
        repeat (3) do_acc(0, 100, 32'h0001);
        check("n0_pre_fire", dut.pot_q[0], 300);
        do_fire(1'b0, 0, 0, 0, 2, 5);
        check("n0_after_fire", dut.pot_q[0], 0);
        check_all("basic");

        // Saturation at both ends
        do_acc(0, 32767, 1 << 5);
        do_acc(0, 32767, 1 << 5);
        do_acc(0, -32768, 1 << 6);
        do_acc(0, -32768, 1 << 6);
        do_acc(0, -32768, 1 << 6);
        check("sat_pos", dut.pot_q[5], 32767);
        check("sat_neg", dut.pot_q[6], -32768);

        // Reset-by-subtract and leak clamped at zero
        do_reset();
        set_cfg(100, 10, 1);
        do_acc(1, 130, 32'h0001);
        do_acc(1, -7, 32'h0002);
        do_fire(1'b0, 0, 0, 0, -1, 0);
        check("sub_reset", dut.pot_q[16], 30);
        check("leak_clamp", dut.pot_q[17], 0);
        check_all("mode1");

        // Randomized rounds, last accumulate coincident with fire_req
        for (int rnd = 0; rnd < 6; rnd++) begin
            set_cfg(int'($urandom_range(0, 6000)) - 3000, int'($urandom_range(0, 800)),
                    int'($urandom_range(0, 1)));
            for (int k = 0; k < 25; k++) begin
                r16 = 16'($urandom);
                do_acc(int'($urandom_range(0, 3)), int'($signed(r16)), int'(16'($urandom)));
            end
            r16 = 16'($urandom);
            do_fire(1'b1, int'($urandom_range(0, 3)), int'($signed(r16)),
                    int'(16'($urandom)), -1, 0);
            check_all($sformatf("rnd%0d", rnd));
        end

        // Asynchronous reset while group 1 is pending
        set_cfg(50, 5, 0);
        do_acc(1, 200, 32'hFFFF);
        @(negedge clk);
        fire_req = 1'b1;
        @(posedge clk);
        #1 fire_req = 1'b0;
        @(negedge clk);
        check("mid_grp0", spk_group, 0);
        spk_ready = 1'b1;
        @(negedge clk);
        spk_ready = 1'b0;
        check("mid_valid", spk_valid, 1);
        check("mid_grp1", spk_group, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_spk_valid", spk_valid, 0);
        check("async_busy", busy, 0);
        check("async_fire_done", fire_done, 0);
        model_clear();
        repeat (3) begin
            @(negedge clk);
            check("held_spk_valid", spk_valid, 0);
        end
        rst_n = 1'b1;
        check_all("post_rst");
        @(posedge clk);
        #1 check("post_rst_ready", acc_ready, 1);
        check("post_rst_no_spk", spk_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nvm_neuron_array.md
NVM_NEURON_ARRAY -- requirements
Module: nvm_neuron_array

Interface
REQ-001 SHALL have parameter N_NEURONS, default 64: neuron count; multiple of LANES.
REQ-002 SHALL have parameter LANES, default 16: neurons updated per accumulate beat, one per connection bit.
REQ-003 SHALL have parameter POT_W, default 16: signed membrane-potential width.
REQ-004 SHALL have parameter STIM_W, default 16: signed stimulus width, STIM_W <= POT_W.
REQ-005 SHALL have ports, clock and reset first, as listed below; G = N_NEURONS/LANES, GW = max(1, clog2(G)).
- wb_clk_i  in  1  sole clock, rising edge.
- wb_rst_ni  in  1  asynchronous active-low reset.
- cfg_threshold  in  POT_W  signed firing threshold.
- cfg_leak  in  POT_W-1  unsigned leak magnitude.
- cfg_reset_mode  in  1  0 = reset-to-zero, 1 = reset-by-subtract.
- acc_valid / acc_ready  in / out  1  accumulate handshake.
- acc_group  in  GW  neuron group; lane i maps to neuron acc_group*LANES+i.
- acc_stimuli  in  STIM_W  signed stimulus.
- acc_conn  in  LANES  per-lane connection mask.
- fire_req  in  1  single-cycle picture-done pulse.
- busy  out  1  high while firing.
- spk_valid / spk_ready  out / in  1  spike-word handshake.
- spk_group  out  GW  group index of the current spike word.
- spk_data  out  LANES  spike bits, bit i = neuron spk_group*LANES+i.
- fire_done  out  1  single-cycle pulse after the last spike word transfers.

Function
REQ-006 SHALL hold N_NEURONS signed POT_W potentials, all initialised to 0.
REQ-007 SHALL implement FSM states IDLE, FIRE and DONE.
REQ-008 IDLE SHALL drive acc_ready=1; FIRE and DONE SHALL drive acc_ready=0.
REQ-009 On an accumulate transfer (acc_valid & acc_ready), each neuron with acc_conn[i]=1 SHALL take pot + sign-extended acc_stimuli at the same clock edge; neurons with acc_conn[i]=0 SHALL be unchanged.
REQ-010 Accumulation SHALL saturate to the range [-2^(POT_W-1), 2^(POT_W-1)-1]; no wrap-around.
REQ-011 acc_group >= G SHALL leave all potentials unchanged; the transfer still completes.
REQ-012 fire_req in IDLE SHALL move the FSM to FIRE next cycle with the group counter at 0.
REQ-013 An accumulate transfer in the same cycle as fire_req SHALL be applied before firing.
REQ-014 fire_req outside IDLE SHALL be ignored.
REQ-015 In FIRE, spk_valid=1, spk_group=counter, and spk_data[i] = (pot[counter*LANES+i] >= cfg_threshold), signed compare.
REQ-016 spk_data and spk_group SHALL remain stable while spk_valid=1 and spk_ready=0.
REQ-017 On each spike transfer, every spiking neuron of the group SHALL take 0 (mode 0) or pot - cfg_threshold, saturated (mode 1).
REQ-018 On each spike transfer, every non-spiking neuron SHALL move toward 0 by cfg_leak, clamped at 0 without crossing zero.
REQ-019 On each spike transfer the counter SHALL increment; the transfer of group G-1 SHALL move the FSM to DONE.
REQ-020 DONE SHALL pulse fire_done for one cycle, then return to IDLE.
REQ-021 busy SHALL be 1 in FIRE and DONE, 0 in IDLE.
REQ-022 cfg_* SHALL be sampled every cycle; software changes them only in IDLE.

Reset
REQ-023 Asserting wb_rst_ni=0 SHALL immediately, without a clock edge, drive: state IDLE, all potentials 0, counter 0, spk_valid 0, fire_done 0, busy 0.
REQ-024 Reset mid-FIRE SHALL abort the fire sequence with no further spike words emitted.
REQ-025 After reset release, acc_ready SHALL be 1 on the first clock edge.

Structure
REQ-026 Package nvm_neuron_pkg SHALL hold the FSM state enum, the reset-mode constants RST_ZERO=0 and RST_SUB=1, and default parameter values.
REQ-027 A sub-module nvm_sat_addsub (signed saturating add/subtract, POT_W parameter) SHALL be instantiated per lane and shared by the accumulate and fire paths.

Verification
REQ-028 Reset, then 3 transfers of stimuli +100, group 0, conn 0x0001, threshold 250, mode 0, fire_req -> group 0 word spk_data=0x0001, neuron 0 potential 0 afterwards.
REQ-029 Stimuli 0x7FFF twice to neuron 5 -> potential 32767 (saturated); stimuli -32768 three times to neuron 6 -> potential -32768.
REQ-030 Mode 1, threshold 100, potential 130 -> spike, potential 30; non-spiking potential -7 with leak 10 -> 0.
REQ-031 spk_ready held low 5 cycles during group 2 -> spk_group=2 and spk_data stable, exactly 4 words total for the default configuration, one fire_done pulse.
REQ-032 fire_req during FIRE -> ignored; acc_valid during FIRE -> acc_ready=0 and potentials unchanged.
REQ-033 wb_rst_ni low while group 1 is pending -> spk_valid falls without a clock edge; all potentials read 0 after release.
